// File: rtl/fdiv_arbiter.sv
// Round-robin arbiter sharing one pipelined fdiv unit among NREQ requesters.
// An in-order tag FIFO routes each result back to its issuer; a credit count
// bounds in-flight operations and a small FSM drains the pipe on flush.
module fdiv_arbiter #(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned MAX_INFLIGHT = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NREQ-1:0]                       req_valid,
    output logic [NREQ-1:0]                       req_ready,
    input  logic [NREQ*32-1:0]                    req_x1,
    input  logic [NREQ*32-1:0]                    req_x2,
    output logic                                  fdiv_en,
    output logic [31:0]                           fdiv_x1,
    output logic [31:0]                           fdiv_x2,
    input  logic [31:0]                           fdiv_y,
    input  logic                                  fdiv_done,
    input  logic                                  fdiv_busy,
    output logic [NREQ-1:0]                       resp_valid,
    output logic [31:0]                           resp_y,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight,
    input  logic                                  flush,
    output logic                                  flush_ack,
    output logic                                  err
);

    localparam int unsigned TAG_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t             r_state;
    logic [TAG_W-1:0]   r_ptr;
    logic [TAG_W-1:0]   r_fifo [MAX_INFLIGHT];
    logic [PTR_W-1:0]   r_wr;
    logic [PTR_W-1:0]   r_rd;
    logic [CNT_W-1:0]   r_inflight;
    logic               r_fdiv_en;
    logic [31:0]        r_fdiv_x1;
    logic [31:0]        r_fdiv_x2;
    logic [NREQ-1:0]    r_resp_valid;
    logic [31:0]        r_resp_y;
    logic               r_flush_ack;
    logic               r_err;

    logic               w_found;
    logic [TAG_W-1:0]   w_win;
    logic [31:0]        w_sel_x1;
    logic [31:0]        w_sel_x2;
    logic               w_elig;
    logic               w_push;
    logic               w_pop;
    logic [TAG_W-1:0]   w_head;
    logic [TAG_W-1:0]   w_ptr_next;

    // Round-robin search starting at r_ptr; first valid requester wins.
    always_comb begin
        w_found  = 1'b0;
        w_win    = '0;
        w_sel_x1 = '0;
        w_sel_x2 = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[TAG_W'((32'(r_ptr) + k) % NREQ)]) begin
                w_found  = 1'b1;
                w_win    = TAG_W'((32'(r_ptr) + k) % NREQ);
                w_sel_x1 = req_x1[32*((32'(r_ptr) + k) % NREQ) +: 32];
                w_sel_x2 = req_x2[32*((32'(r_ptr) + k) % NREQ) +: 32];
            end
        end
    end

    // Grant qualification; a same-cycle pop does not free a credit.
    assign w_elig     = (r_state == S_RUN) && !flush && !fdiv_busy &&
                        (r_inflight < CNT_W'(MAX_INFLIGHT));
    assign w_push     = w_elig && w_found;
    assign w_pop      = fdiv_done && (r_inflight != '0);
    assign w_head     = r_fifo[r_rd];
    assign w_ptr_next = (w_win == TAG_W'(NREQ - 1)) ? '0 : w_win + TAG_W'(1);
    assign req_ready  = w_push ? (NREQ'(1) << w_win) : '0;

    // Issue register: one-cycle strobe, operands hold between issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fdiv_en <= 1'b0;
            r_fdiv_x1 <= '0;
            r_fdiv_x2 <= '0;
        end else begin
            r_fdiv_en <= w_push;
            if (w_push) begin
                r_fdiv_x1 <= w_sel_x1;
                r_fdiv_x2 <= w_sel_x2;
            end
        end
    end

    // Round-robin pointer advances past the winner on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_push) begin
            r_ptr <= w_ptr_next;
        end
    end

    // Tag FIFO storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr] <= w_win;
        end
    end

    // Tag FIFO pointers; depth is a power of two so they wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PTR_W'(1);
            end
        end
    end

    // In-flight count doubles as the FIFO occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Result return: route registered result to the popped tag; flag orphans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid <= '0;
            r_resp_y     <= '0;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= w_pop ? (NREQ'(1) << w_head) : '0;
            if (w_pop) begin
                r_resp_y <= fdiv_y;
            end
            if (fdiv_done && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

    // Flush FSM: RUN -> DRAIN on flush, DRAIN -> ACK when empty, ACK pulses once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_flush_ack <= 1'b0;
        end else begin
            r_flush_ack <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (r_inflight == '0) begin
                        r_state     <= S_ACK;
                        r_flush_ack <= 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_RUN;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign fdiv_en    = r_fdiv_en;
    assign fdiv_x1    = r_fdiv_x1;
    assign fdiv_x2    = r_fdiv_x2;
    assign resp_valid = r_resp_valid;
    assign resp_y     = r_resp_y;
    assign inflight   = r_inflight;
    assign flush_ack  = r_flush_ack;
    assign err        = r_err;

endmodule

// File: tb/tb_fdiv_arbiter.sv
// Bench for fdiv_arbiter: a behavioural fdiv stand-in plus a queue-based
// reference model of grant order, result routing, credits and flush.
module tb_fdiv_arbiter;

    localparam int N    = 4;
    localparam int MAXI = 8;
    localparam int LAT  = 4;
    localparam int CW   = $clog2(MAXI + 1);

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_x1;
    logic [N*32-1:0]   req_x2;
    logic              fdiv_en;
    logic [31:0]       fdiv_x1;
    logic [31:0]       fdiv_x2;
    logic [31:0]       fdiv_y;
    logic              fdiv_done;
    logic              fdiv_busy;
    logic [N-1:0]      resp_valid;
    logic [31:0]       resp_y;
    logic [CW-1:0]     inflight;
    logic              flush;
    logic              flush_ack;
    logic              err;

    fdiv_arbiter #(.NREQ(N), .MAX_INFLIGHT(MAXI)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x1(req_x1), .req_x2(req_x2),
        .fdiv_en(fdiv_en), .fdiv_x1(fdiv_x1), .fdiv_x2(fdiv_x2),
        .fdiv_y(fdiv_y), .fdiv_done(fdiv_done), .fdiv_busy(fdiv_busy),
        .resp_valid(resp_valid), .resp_y(resp_y), .inflight(inflight),
        .flush(flush), .flush_ack(flush_ack), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Single-precision helpers for normal operands with moderate exponents.
    function automatic real sp2r(input logic [31:0] b);
        logic [63:0] d;
        d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction

    function automatic logic [31:0] fdiv_div(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) / sp2r(b));
    endfunction

    function automatic logic [31:0] rnd_op();
        return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // fdiv stand-in: fixed latency, in order, done can be held off.
    typedef struct {
        logic [31:0] y;
        int          due;
    } sp_t;
    sp_t         sq[$];
    int          cyc;
    logic        stub_done;
    logic [31:0] stub_y;
    logic        hold;
    logic        spur;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sq.delete();
            stub_done <= 1'b0;
            stub_y    <= '0;
            cyc       <= 0;
        end else begin
            cyc <= cyc + 1;
            if (stub_done && sq.size() > 0) sq.delete(0);
            if (fdiv_en) sq.push_back('{fdiv_div(fdiv_x1, fdiv_x2), cyc + LAT});
            if (sq.size() > 0 && sq[0].due <= cyc && !hold) begin
                stub_done <= 1'b1;
                stub_y    <= sq[0].y;
            end else begin
                stub_done <= 1'b0;
            end
        end
    end

    assign fdiv_done = stub_done | spur;
    assign fdiv_y    = spur ? 32'hDEADBEEF : stub_y;

    // Reference model state.
    typedef struct {
        int          tag;
        logic [31:0] x1;
        logic [31:0] x2;
    } ent_t;
    ent_t         m_q[$];
    int           m_ptr;
    int           m_mode;   // 0 run, 1 drain, 2 ack
    logic         m_err;
    logic         e_en;
    logic [31:0]  e_x1;
    logic [31:0]  e_x2;
    logic [N-1:0] e_rv;
    logic [31:0]  e_ry;
    logic         e_ack;
    logic [N-1:0] m_grants[$];
    logic [31:0]  x1a[N];
    logic [31:0]  x2a[N];
    logic         regen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_x1[32*i +: 32] = x1a[i];
            req_x2[32*i +: 32] = x2a[i];
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr  = 0;
        m_mode = 0;
        m_err  = 1'b0;
        e_en   = 1'b0;
        e_x1   = '0;
        e_x2   = '0;
        e_rv   = '0;
        e_ry   = '0;
        e_ack  = 1'b0;
    endtask

    // One clock: check the grant before the edge, registered outputs after it.
    task automatic tick();
        int           win;
        logic         elig;
        logic [N-1:0] exp_rdy;
        logic         pop;
        logic         spur_s;
        logic         fl_s;
        int           cnt_pre;
        ent_t         e;
        #2;
        elig = (m_mode == 0) && !flush && !fdiv_busy && (m_q.size() < MAXI);
        win  = -1;
        if (elig) begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
        end
        exp_rdy = (win >= 0) ? (N'(1) << win) : '0;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (req_ready != '0) m_grants.push_back(req_ready);
        pop     = fdiv_done && (m_q.size() > 0);
        spur_s  = fdiv_done && (m_q.size() == 0);
        fl_s    = flush;
        cnt_pre = m_q.size();
        @(posedge clk);
        #1;
        e_rv = '0;
        e    = '{0, 32'd0, 32'd0};
        if (pop) begin
            e    = m_q.pop_front();
            e_rv = N'(1) << e.tag;
            e_ry = fdiv_div(e.x1, e.x2);
        end
        if (spur_s) m_err = 1'b1;
        if (win >= 0) begin
            m_q.push_back('{win, x1a[win], x2a[win]});
            m_ptr = (win + 1) % N;
            e_en  = 1'b1;
            e_x1  = x1a[win];
            e_x2  = x2a[win];
        end else begin
            e_en = 1'b0;
        end
        case (m_mode)
            0:       if (fl_s) m_mode = 1;
            1:       if (cnt_pre == 0) m_mode = 2;
            default: m_mode = 0;
        endcase
        e_ack = (m_mode == 2);
        chk("fdiv_en", 32'(fdiv_en), 32'(e_en));
        chk("fdiv_x1", fdiv_x1, e_x1);
        chk("fdiv_x2", fdiv_x2, e_x2);
        chk("resp_valid", 32'(resp_valid), 32'(e_rv));
        if (e_rv != '0) chk("resp_y", resp_y, e_ry);
        if (pop && e.x1 == 32'h40400000 && e.x2 == 32'h3F800000)
            chk("req_3div1", resp_y, 32'h40400000);
        chk("inflight", 32'(inflight), 32'(m_q.size()));
        chk("flush_ack", 32'(flush_ack), 32'(e_ack));
        chk("err", 32'(err), 32'(m_err));
        if (regen && win >= 0) begin
            x1a[win] = rnd_op();
            x2a[win] = rnd_op();
            pack();
        end
    endtask

    task automatic drain();
        req_valid = '0;
        flush     = 1'b0;
        fdiv_busy = 1'b0;
        hold      = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (m_q.size() == 0 && !fdiv_en && e_rv == '0 && m_mode == 0) break;
        end
        chk("drain_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        int p0;
        logic seen;
        rst       = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        fdiv_busy = 1'b0;
        hold      = 1'b0;
        spur      = 1'b0;
        regen     = 1'b1;
        for (int i = 0; i < N; i++) begin
            x1a[i] = rnd_op();
            x2a[i] = rnd_op();
        end
        pack();
        model_reset();
        #1;
        chk("rst_fdiv_en", 32'(fdiv_en), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round robin with all requesters valid; one lane carries 3.0/1.0.
        x1a[2] = 32'h40400000;
        x2a[2] = 32'h3F800000;
        pack();
        p0 = m_ptr;
        m_grants.delete();
        req_valid = '1;
        for (int i = 0; i < 40; i++) tick();
        for (int i = 0; i < 8; i++) begin
            if (i < m_grants.size()) chk("rr_order", 32'(m_grants[i]), 32'(N'(1) << ((p0 + i) % N)));
            else chk("rr_order_missing", 32'(i), 32'(m_grants.size()));
        end
        drain();

        // Single operation 1.0 / 2.0 from requester 0.
        regen  = 1'b0;
        x1a[0] = 32'h3F800000;
        x2a[0] = 32'h40000000;
        pack();
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        chk("single_inflight1", 32'(inflight), 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (resp_valid != '0) break;
        end
        chk("single_rv", 32'(resp_valid), 32'h1);
        chk("single_y", resp_y, 32'h3F000000);
        chk("single_inflight0", 32'(inflight), 32'd0);
        regen = 1'b1;
        drain();

        // Credit cap with results held back.
        hold      = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 15; i++) tick();
        chk("cap_inflight", 32'(inflight), MAXI);
        chk("cap_ready", 32'(req_ready), 32'd0);
        hold = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        drain();

        // fdiv_busy blocks issue for three cycles.
        req_valid = 4'b0010;
        fdiv_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_ready", 32'(req_ready), 32'd0);
            chk("busy_en", 32'(fdiv_en), 32'd0);
        end
        fdiv_busy = 1'b0;
        tick();
        chk("busy_release_en", 32'(fdiv_en), 32'd1);
        drain();

        // Flush with three operations in flight.
        hold      = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 3; i++) tick();
        chk("flush_pre_inflight", 32'(inflight), 32'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("flush_no_grant", 32'(req_ready), 32'd0);
        end
        hold = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (flush_ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk("flush_ack_seen", 32'(seen), 32'd1);
        tick();
        chk("flush_resume", 32'(|req_ready), 32'd1);
        drain();

        // Orphan fdiv_done at idle sets sticky err.
        spur = 1'b1;
        tick();
        spur = 1'b0;
        chk("spur_err", 32'(err), 32'd1);
        chk("spur_rv", 32'(resp_valid), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        chk("spur_err_sticky", 32'(err), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 300; i++) begin
            req_valid = N'($urandom);
            fdiv_busy = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            hold      = ($urandom_range(0, 9) == 0);
            tick();
        end
        drain();

        // Asynchronous reset with five operations in flight.
        hold      = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_q.size() >= 5) break;
        end
        req_valid = '0;
        chk("pre_rst_inflight", 32'(inflight), 32'd5);
        rst = 1'b1;
        #1;
        chk("arst_fdiv_en", 32'(fdiv_en), 32'd0);
        chk("arst_x1", fdiv_x1, 32'd0);
        chk("arst_x2", fdiv_x2, 32'd0);
        chk("arst_rv", 32'(resp_valid), 32'd0);
        chk("arst_ry", resp_y, 32'd0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        chk("arst_ack", 32'(flush_ack), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hold = 1'b0;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_ptr0", 32'(req_ready), 32'h1);
        tick();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fdiv_arbiter.md
Name: fdiv_arbiter

Overview:
- Shares one pipelined fdiv unit (en/x1/x2 in, y/done/busy out, in-order results) among NREQ requesters.
- Round-robin issue, at most one operation per cycle.
- In-order tag FIFO routes each result back to the requester that issued it.
- Credit limit caps in-flight operations; flush FSM drains the pipe on request. Sits between FPU-issuing clients and the fdiv instance.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_INFLIGHT, 16, tag FIFO depth / in-flight cap (power of 2, >= fdiv latency 11 for full throughput)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset; fdiv shares this reset
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  one-hot grant (combinational); handshake = valid&ready
req_x1  in  NREQ*32  dividends, requester i at [32i+31:32i]
req_x2  in  NREQ*32  divisors, same packing
fdiv_en  out  1  issue strobe to fdiv
fdiv_x1  out  32  dividend to fdiv
fdiv_x2  out  32  divisor to fdiv
fdiv_y  in  32  fdiv result
fdiv_done  in  1  fdiv result valid
fdiv_busy  in  1  fdiv cannot accept this cycle
resp_valid  out  NREQ  one-hot result pulse
resp_y  out  32  result data, valid with resp_valid
inflight  out  $clog2(MAX_INFLIGHT+1)  operations issued, result not yet returned
flush  in  1  request drain (level or pulse, sampled in RUN)
flush_ack  out  1  one-cycle pulse: pipe empty after flush
err  out  1  sticky: fdiv_done with empty tag FIFO

Behaviour:
- Reset (async): fdiv_en=0, fdiv_x1=fdiv_x2=0, resp_valid=0, resp_y=0, inflight=0, flush_ack=0, err=0, rr pointer=0, FIFO empty, FSM=RUN. In-flight ops are dropped; fdiv is reset by the same rst.
- FSM states RUN, DRAIN, ACK.
  - RUN: flush=1 -> DRAIN; no grant that cycle.
  - DRAIN: no grants; inflight==0 -> ACK.
  - ACK: flush_ack=1 for exactly one cycle -> RUN.
  - flush while in DRAIN/ACK is ignored.
- Grant eligibility (cycle t): state==RUN, fdiv_busy==0, inflight<MAX_INFLIGHT. A pop in the same cycle does not free a slot (conservative).
- Round-robin: search req_valid starting at index ptr, wrapping mod NREQ. First valid wins; req_ready has exactly that bit set, else 0. On handshake, ptr <= winner+1 mod NREQ; otherwise ptr holds.
- Issue latency: handshake at t -> fdiv_en=1 at t+1 for one cycle with registered x1/x2 of winner. fdiv_x1/x2 hold last value when fdiv_en=0. Winner index is pushed to the tag FIFO at t.
- Return: fdiv_done at u -> pop tag at u. At u+1: resp_y=fdiv_y (registered), resp_valid[tag]=1 for one cycle. No backpressure on responses; requesters must accept.
- inflight: +1 on push, -1 on pop, unchanged on simultaneous push and pop. Never exceeds MAX_INFLIGHT.
- fdiv_done with FIFO empty: err<=1 (sticky until rst), no resp_valid, inflight stays 0.
- Back-to-back: one issue per cycle sustained while fdiv_busy=0 and credit remains.

Test Plan:
- Single op: req0 x1=0x3F800000, x2=0x40000000 at t -> fdiv_en at t+1; resp_valid=0001, resp_y=0x3F000000 one cycle after fdiv_done; inflight 0->1->0.
- All 4 requesters valid continuously, busy=0 -> grants 0,1,2,3,0,... one per cycle. Responses return in the same order, each to the correct one-hot bit. req2 3.0/1.0 (0x40400000/0x3F800000) -> 0x40400000.
- MAX_INFLIGHT=4, fdiv_done stalled (stub): after 4 grants req_ready=0, inflight=4. One done -> inflight=3, next grant the following cycle.
- fdiv_busy=1 for 3 cycles with req1 valid -> req_ready=0 and fdiv_en=0 throughout; grant the cycle busy drops.
- flush with 3 in flight -> no grants until inflight==0, then flush_ack pulses once and grants resume the next cycle.
- Spurious fdiv_done at idle -> err=1 stays set, resp_valid=0. Assert rst mid-stream with 5 in flight -> all outputs 0 asynchronously, inflight=0, ptr=0.
